spi_tx_sequencer: RTL and testbench

- Memory-mapped bus slave that sits between the CPU memory bus and the SPI/LCD controller.
- The CPU queues LCD bytes (with D/C flag), including run-length "repeat" entries for fills, into a FIFO.
- An FSM drains the FIFO by acting as bus master on the SPI controller's register port: it polls busy, then writes each byte.
- Frees the CPU from per-byte busy polling during LCD init and colour fills.

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/spi_tx_sequencer_if.sv | 16 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/spi_tx_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_spi_tx_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transmit sequencer: FSM states, slave register offsets
// and the FIFO entry layout.
package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    WRITE,
    ADVANCE
  } state_t;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_REPEAT = 4'hC;

  typedef struct packed {
    logic [15:0] count;
    logic        dc;
    logic [7:0]  byte_val;
  } tx_entry_t;

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// Simple memory-bus port: master drives address/strobes/write data,
// slave returns read data and ready.
interface spi_tx_sequencer_if;
  logic [31:0] address;
  logic        sel;
  logic        read;
  logic [31:0] read_value;
  logic [3:0]  write_mask;
  logic [31:0] write_value;
  logic        ready;

  modport master (output address, sel, read, write_mask, write_value,
                  input  read_value, ready);
  modport slave  (input  address, sel, read, write_mask, write_value,
                  output read_value, ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; callers never push when full
// or pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/spi_tx_sequencer.sv
// SPI transmit sequencer: CPU queues LCD bytes and run-length fills; an FSM drains
// them by polling the SPI controller's busy flag and writing each byte to it.
module spi_tx_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter logic [31:0] SPI_BASE     = 32'h0004_1000,
  parameter logic [3:0]  SPI_DATA_OFF = 4'h0,
  parameter logic [3:0]  SPI_STAT_OFF = 4'h4
) (
  input  logic               clk,
  input  logic               reset,
  spi_tx_sequencer_if.slave  cpu,
  spi_tx_sequencer_if.master spi,
  output logic               irq_out
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  tx_entry_t     head, push_entry;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [3:0]    off;
  logic          cpu_wr, push_req, flush_now, unused_bits;

  state_t      state_q, state_d;
  logic        enable_q, enable_d, irqen_q, irqen_d, ovf_q, ovf_d;
  logic        partial_q, partial_d, abort_q, abort_d;
  logic [15:0] cur_count_q, cur_count_d;
  logic [7:0]  cur_byte_q, cur_byte_d;
  logic        cur_dc_q, cur_dc_d;
  logic        sel_q, sel_d, rd_q, rd_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] addr_q, addr_d, wval_q, wval_d;

  assign off         = cpu.address[3:0];
  assign cpu_wr      = cpu.sel & (cpu.write_mask != 4'h0);
  assign flush_now   = cpu_wr & (off == OFF_CTRL) & cpu.write_value[1];
  assign cpu.ready   = cpu.sel;
  assign unused_bits = ^{cpu.address[31:4], cpu.read, cpu.write_value[15:9], spi.read_value[31:1]};

  always_comb begin
    push_entry = '{count: 16'd1, dc: cpu.write_value[8], byte_val: cpu.write_value[7:0]};
    push_req   = 1'b0;
    if (cpu_wr && off == OFF_TXDATA) push_req = 1'b1;
    if (cpu_wr && off == OFF_REPEAT) begin
      push_entry.count = cpu.write_value[31:16];
      push_req         = (cpu.write_value[31:16] != 16'd0);
    end
  end
  // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
  assign fifo_push = push_req & ~fifo_full;

  always_comb begin
    cpu.read_value = '0;
    if (cpu.sel) begin
      case (off)
        OFF_STATUS: cpu.read_value = {16'h0, 8'(fifo_count), 4'h0, ovf_q,
                                      state_q != IDLE, fifo_full, fifo_empty};
        OFF_CTRL:   cpu.read_value = {29'h0, irqen_q, 1'b0, enable_q};
        default:    cpu.read_value = '0;
      endcase
    end
  end

  always_comb begin
    enable_d = enable_q;
    irqen_d  = irqen_q;
    ovf_d    = ovf_q;
    if (cpu_wr && off == OFF_CTRL) begin
      enable_d = cpu.write_value[0];
      irqen_d  = cpu.write_value[2];
    end
    if (cpu_wr && off == OFF_STATUS && cpu.write_value[3]) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (flush_now) ovf_d = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    cur_count_d = cur_count_q;
    cur_byte_d  = cur_byte_q;
    cur_dc_d    = cur_dc_q;
    partial_d   = partial_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && !flush_now && (partial_q || !fifo_empty)) begin
          if (!partial_q) begin
            cur_count_d = head.count;
            cur_byte_d  = head.byte_val;
            cur_dc_d    = head.dc;
            partial_d   = 1'b1;
          end
          state_d = POLL;
        end
      end
      POLL: begin
        if (spi.ready) begin
          if (abort_q || flush_now)  state_d = IDLE;
          else if (!spi.read_value[0]) state_d = WRITE;
        end
      end
      WRITE: begin
        if (spi.ready) state_d = (abort_q || flush_now) ? IDLE : ADVANCE;
      end
      ADVANCE: begin
        if (abort_q || flush_now) begin
          state_d = IDLE;
        end else begin
          cur_count_d = cur_count_q - 16'd1;
          if (cur_count_d == 16'd0) begin
            fifo_pop  = 1'b1;
            partial_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = enable_q ? POLL : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_now) partial_d = 1'b0;
    // A flush that lands mid-transaction is remembered until that transaction completes.
    abort_d = (abort_q | flush_now) & (state_d != IDLE);
  end

  always_comb begin
    sel_d  = 1'b0;
    rd_d   = 1'b0;
    mask_d = 4'h0;
    addr_d = '0;
    wval_d = '0;
    if (state_d == POLL) begin
      sel_d  = 1'b1;
      rd_d   = 1'b1;
      addr_d = SPI_BASE + 32'(SPI_STAT_OFF);
    end else if (state_d == WRITE) begin
      sel_d  = 1'b1;
      mask_d = 4'hF;
      addr_d = SPI_BASE + 32'(SPI_DATA_OFF);
      wval_d = {23'h0, cur_dc_d, cur_byte_d};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      irqen_q     <= 1'b0;
      ovf_q       <= 1'b0;
      partial_q   <= 1'b0;
      abort_q     <= 1'b0;
      cur_count_q <= '0;
      cur_byte_q  <= '0;
      cur_dc_q    <= 1'b0;
      sel_q       <= 1'b0;
      rd_q        <= 1'b0;
      mask_q      <= '0;
      addr_q      <= '0;
      wval_q      <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      irqen_q     <= irqen_d;
      ovf_q       <= ovf_d;
      partial_q   <= partial_d;
      abort_q     <= abort_d;
      cur_count_q <= cur_count_d;
      cur_byte_q  <= cur_byte_d;
      cur_dc_q    <= cur_dc_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wval_q      <= wval_d;
    end
  end

  assign spi.sel         = sel_q;
  assign spi.read        = rd_q;
  assign spi.write_mask  = mask_q;
  assign spi.address     = addr_q;
  assign spi.write_value = wval_q;
  assign irq_out         = fifo_empty & (state_q == IDLE) & irqen_q;

  sync_fifo #(.WIDTH($bits(tx_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush_now),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Bench for spi_tx_sequencer: directed scenarios plus randomized traffic checked
// against an entry-expansion reference model and a behavioural SPI controller.
module tb_spi_tx_sequencer;
  localparam logic [3:0] TX = 4'h0, ST = 4'h4, CT = 4'h8, RP = 4'hC;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  spi_tx_sequencer_if cpu ();
  spi_tx_sequencer_if spi ();

  spi_tx_sequencer #(.DEPTH(16), .SPI_BASE(32'h0004_1000)) dut (
    .clk     (clk),
    .reset   (reset),
    .cpu     (cpu),
    .spi     (spi),
    .irq_out (irq)
  );

  always #5 clk = ~clk;

  // Behavioural SPI controller: busy for a programmable number of status reads,
  // optional write stalls, and a log of every completed data write.
  logic        spi_stall = 1'b0, rand_mode = 1'b0, rnd_stall = 1'b0, rnd_busy = 1'b0;
  int unsigned stat_reads = 0, busy_until = 0, sel_cycles = 0, bad_addr = 0;
  logic [31:0] wr_log [$];
  logic [31:0] exp_q [$];

  assign spi.ready = spi.sel & ~(rand_mode ? (rnd_stall & (spi.write_mask != 4'h0))
                                           : (spi_stall & (spi.write_mask != 4'h0)));
  assign spi.read_value = {31'h0, (stat_reads < busy_until) | (rand_mode & rnd_busy)};

  always @(posedge clk) begin
    rnd_stall <= ($urandom_range(0, 3) == 0);
    rnd_busy  <= ($urandom_range(0, 2) == 0);
    if (spi.sel) sel_cycles <= sel_cycles + 1;
    if (spi.ready && spi.read) begin
      stat_reads <= stat_reads + 1;
      if (spi.address != 32'h0004_1004) bad_addr <= bad_addr + 1;
    end
    if (spi.ready && spi.write_mask != 4'h0) begin
      wr_log.push_back(spi.write_value);
      if (spi.address != 32'h0004_1000 || spi.write_mask != 4'hF) bad_addr <= bad_addr + 1;
    end
  end

  int unsigned n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] v);
    cpu.sel = 1'b1; cpu.read = 1'b0; cpu.address = {28'h0004_200, off};
    cpu.write_mask = 4'hF; cpu.write_value = v;
    tick();
    cpu.sel = 1'b0; cpu.write_mask = 4'h0;
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] v);
    cpu.sel = 1'b1; cpu.read = 1'b1; cpu.address = {28'h0004_200, off}; cpu.write_mask = 4'h0;
    @(negedge clk);
    v = cpu.read_value;
    tick();
    cpu.sel = 1'b0; cpu.read = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(off, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_writes(input int unsigned n, input string tag);
    int unsigned k;
    k = 0;
    while (wr_log.size() < n && k < 2000) begin tick(); k++; end
    repeat (8) tick();
    chk(tag, 32'(wr_log.size()), 32'(n));
  endtask

  task automatic wait_wr_pending(input int unsigned have, input string tag);
    int unsigned k;
    k = 0;
    while (!(spi.sel && spi.write_mask != 4'h0 && wr_log.size() == have) && k < 500) begin
      tick(); k++;
    end
    chk(tag, 32'(k < 500), 32'd1);
  endtask

  initial begin
    int unsigned base, sr0, sc0, k, nent, c;
    logic [31:0] w, v;

    reset = 1'b1;
    cpu.sel = 1'b0; cpu.read = 1'b0; cpu.address = '0; cpu.write_mask = '0; cpu.write_value = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_rv_unsel", cpu.read_value, 32'h0);
    chk("rst_spi_sel", 32'(spi.sel), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk_reg("rst_status", ST, 32'h0000_0001);
    chk_reg("rst_ctrl", CT, 32'h0);
    chk_reg("rst_other", 4'h1, 32'h0);

    // 1: single byte with two busy polls
    busy_until = stat_reads + 2;
    sr0 = stat_reads; base = wr_log.size();
    bus_wr(CT, 32'h1);
    bus_wr(TX, 32'h0000_012A);
    wait_writes(base + 1, "t1_nwr");
    chk("t1_data", wr_log[base], 32'h0000_012A);
    chk("t1_polls", 32'(stat_reads - sr0), 32'd3);
    chk_reg("t1_status", ST, 32'h0000_0001);

    // 2: repeat fill, pop only after the last byte, irq when drained
    bus_wr(CT, 32'h4);
    chk("t2_irq_empty", 32'(irq), 32'h1);
    bus_wr(RP, 32'h0003_00F0);
    chk("t2_irq_pend", 32'(irq), 32'h0);
    base = wr_log.size();
    bus_wr(CT, 32'h5);
    k = 0;
    while (wr_log.size() < base + 2 && k < 500) begin tick(); k++; end
    spi_stall = 1'b1;
    repeat (6) tick();
    chk_reg("t2_no_pop", ST, 32'h0000_0104);
    spi_stall = 1'b0;
    wait_writes(base + 3, "t2_nwr");
    for (int i = 0; i < 3; i++) chk("t2_data", wr_log[base + i], 32'h0000_00F0);
    chk_reg("t2_status", ST, 32'h0000_0001);
    chk("t2_irq_done", 32'(irq), 32'h1);

    // 3: overflow with engine disabled
    bus_wr(CT, 32'h0);
    base = wr_log.size();
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      w = {23'h0, 1'(i & 1), 8'(i * 7 + 3)};
      bus_wr(TX, w);
      if (i < 16) exp_q.push_back(w);
    end
    chk_reg("t3_full", ST, 32'h0000_100A);
    bus_wr(ST, 32'h8);
    chk_reg("t3_ovf_clr", ST, 32'h0000_1002);
    bus_wr(CT, 32'h1);
    wait_writes(base + 16, "t3_nwr");
    for (int i = 0; i < 16; i++) chk("t3_data", wr_log[base + i], exp_q[i]);
    chk_reg("t3_status", ST, 32'h0000_0001);

    // 4: disable mid-fill, then resume the same entry
    bus_wr(CT, 32'h0);
    bus_wr(RP, 32'h0005_01A5);
    bus_wr(TX, 32'h0000_0055);
    base = wr_log.size();
    bus_wr(CT, 32'h1);
    wait_wr_pending(base + 1, "t4_pend");
    spi_stall = 1'b1;
    bus_wr(CT, 32'h0);
    spi_stall = 1'b0;
    repeat (12) tick();
    chk("t4_paused", 32'(wr_log.size()), 32'(base + 2));
    chk_reg("t4_status", ST, 32'h0000_0200);
    bus_wr(CT, 32'h1);
    wait_writes(base + 6, "t4_nwr");
    for (int i = 0; i < 5; i++) chk("t4_data", wr_log[base + i], 32'h0000_01A5);
    chk("t4_tail", wr_log[base + 5], 32'h0000_0055);
    chk_reg("t4_done", ST, 32'h0000_0001);

    // 5: flush while a write is stalled
    bus_wr(CT, 32'h0);
    bus_wr(RP, 32'h0004_0033);
    bus_wr(TX, 32'h0000_0144);
    base = wr_log.size();
    spi_stall = 1'b1;
    bus_wr(CT, 32'h1);
    wait_wr_pending(base, "t5_pend");
    bus_wr(CT, 32'h3);
    repeat (3) tick();
    spi_stall = 1'b0;
    repeat (10) tick();
    chk("t5_nwr", 32'(wr_log.size()), 32'(base + 1));
    chk("t5_data", wr_log[base], 32'h0000_0033);
    chk_reg("t5_status", ST, 32'h0000_0001);
    chk_reg("t5_ctrl", CT, 32'h0000_0001);
    sc0 = sel_cycles;
    repeat (10) tick();
    chk("t5_quiet", 32'(sel_cycles), 32'(sc0));

    // 6: reset while polling a busy controller
    busy_until = stat_reads + 1000000;
    bus_wr(CT, 32'h5);
    bus_wr(TX, 32'h0000_00AA);
    k = 0;
    while (!(spi.sel && spi.read) && k < 100) begin tick(); k++; end
    repeat (3) tick();
    chk("t6_polling", 32'(spi.sel & spi.read), 32'h1);
    reset = 1'b1;
    tick();
    chk("t6_sel_drop", {spi.sel, spi.read, spi.write_mask}, 32'h0);
    reset = 1'b0;
    busy_until = stat_reads;
    tick();
    chk_reg("t6_status", ST, 32'h0000_0001);
    chk_reg("t6_ctrl", CT, 32'h0);
    chk("t6_irq", 32'(irq), 32'h0);

    // 7: randomized traffic against the entry-expansion model
    rand_mode = 1'b1;
    bus_wr(CT, 32'h1);
    for (int b = 0; b < 4; b++) begin
      nent = $urandom_range(4, 12);
      base = wr_log.size();
      exp_q.delete();
      for (int e = 0; e < int'(nent); e++) begin
        w = $urandom;
        v = {23'h0, w[8:0]};
        if ($urandom_range(0, 1) == 0) begin
          bus_wr(TX, w);
          exp_q.push_back(v);
        end else begin
          c = $urandom_range(0, 3);
          w[31:16] = 16'(c);
          bus_wr(RP, w);
          for (int j = 0; j < int'(c); j++) exp_q.push_back(v);
        end
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_writes(base + exp_q.size(), "rnd_nwr");
      for (int i = 0; i < exp_q.size(); i++) chk("rnd_data", wr_log[base + i], exp_q[i]);
    end
    rand_mode = 1'b0;
    repeat (4) tick();
    chk_reg("rnd_status", ST, 32'h0000_0001);
    chk("master_addr", 32'(bad_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
